// File: rtl/tl_buffer_queued_if.sv
// TileLink-UL A/D channel bundle seen from one side of a link.
// The master drives A and accepts D; the slave accepts A and drives D.
interface tl_buffer_queued_if #(
   parameter int AW = 108,
   parameter int DW = 80
);
   logic          a_valid;
   logic          a_ready;
   logic [AW-1:0] a_bits;
   logic          d_valid;
   logic          d_ready;
   logic [DW-1:0] d_bits;

   modport master (
      output a_valid,
      output a_bits,
      input  a_ready,
      input  d_valid,
      input  d_bits,
      output d_ready
   );

   modport slave (
      input  a_valid,
      input  a_bits,
      output a_ready,
      output d_valid,
      output d_bits,
      input  d_ready
   );
endinterface

// File: rtl/tl_buffer_queued.sv
// TileLink-UL buffer: independent ready/valid queues on the A (in->out) and
// D (out->in) channels. A zero-depth queue collapses to plain wires.
module tl_buffer_queued_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int FLOW  = 0,
   parameter int PIPE  = 0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enq_valid,
   output logic         enq_ready,
   input  logic [W-1:0] enq_bits,
   output logic         deq_valid,
   input  logic         deq_ready,
   output logic [W-1:0] deq_bits
);
   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_s;
         assign unused_s  = ^{clock, reset};
         assign deq_valid = enq_valid;
         assign deq_bits  = enq_bits;
         assign enq_ready = deq_ready;
      end else begin : g_fifo
         localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
         localparam int CW = $clog2(DEPTH + 1);

         logic [W-1:0]  ram_r [DEPTH];
         logic [PW-1:0] enq_ptr_r;
         logic [PW-1:0] deq_ptr_r;
         logic [CW-1:0] count_r;
         logic          full_s;
         logic          empty_s;
         logic          enq_ready_s;
         logic          deq_valid_s;
         logic [W-1:0]  deq_bits_s;
         logic          do_enq_s;
         logic          do_deq_s;

         // Pointers wrap explicitly so non-power-of-two depths never index past the RAM.
         function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
            if (p == PW'(DEPTH - 1)) begin
               return {PW{1'b0}};
            end else begin
               return p + PW'(1);
            end
         endfunction

         assign full_s  = (count_r == CW'(DEPTH));
         assign empty_s = (count_r == {CW{1'b0}});

         // Handshake, flow bypass and pipe pass-through decisions.
         always_comb begin
            enq_ready_s = !full_s;
            deq_valid_s = !empty_s;
            deq_bits_s  = ram_r[deq_ptr_r];
            do_enq_s    = 1'b0;
            do_deq_s    = 1'b0;
            if ((FLOW != 0) && empty_s) begin
               deq_valid_s = enq_valid;
               deq_bits_s  = enq_bits;
            end else begin
               deq_valid_s = !empty_s;
            end
            if ((PIPE != 0) && full_s) begin
               enq_ready_s = deq_ready;
            end else begin
               enq_ready_s = !full_s;
            end
            // A beat that flows straight through never touches the storage.
            if ((FLOW != 0) && empty_s && deq_ready) begin
               do_enq_s = 1'b0;
               do_deq_s = 1'b0;
            end else begin
               do_enq_s = enq_valid && enq_ready_s;
               do_deq_s = deq_valid_s && deq_ready;
            end
         end

         // Storage write; contents are don't-care until a pointer covers them.
         always_ff @(posedge clock) begin
            if (do_enq_s) begin
               ram_r[enq_ptr_r] <= enq_bits;
            end
         end

         // Pointer and occupancy bookkeeping.
         always_ff @(posedge clock) begin
            if (reset) begin
               enq_ptr_r <= {PW{1'b0}};
               deq_ptr_r <= {PW{1'b0}};
               count_r   <= {CW{1'b0}};
            end else begin
               if (do_enq_s) begin
                  enq_ptr_r <= ptr_inc(enq_ptr_r);
               end
               if (do_deq_s) begin
                  deq_ptr_r <= ptr_inc(deq_ptr_r);
               end
               if (do_enq_s && !do_deq_s) begin
                  count_r <= count_r + CW'(1);
               end else if (!do_enq_s && do_deq_s) begin
                  count_r <= count_r - CW'(1);
               end
            end
         end

         assign enq_ready = enq_ready_s;
         assign deq_valid = deq_valid_s;
         assign deq_bits  = deq_bits_s;
      end
   endgenerate
endmodule

module tl_buffer_queued #(
   parameter int ADDR_W   = 21,
   parameter int DATA_W   = 64,
   parameter int SOURCE_W = 5,
   parameter int SINK_W   = 1,
   parameter int A_DEPTH  = 2,
   parameter int D_DEPTH  = 2,
   parameter int A_FLOW   = 0,
   parameter int A_PIPE   = 0,
   parameter int D_FLOW   = 0,
   parameter int D_PIPE   = 0
) (
   input  logic               clock,
   input  logic               reset,
   tl_buffer_queued_if.slave  auto_in,
   tl_buffer_queued_if.master auto_out
);
   localparam int MASK_W = DATA_W / 8;
   localparam int A_W    = 3 + 3 + 3 + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
   localparam int D_W    = 3 + 2 + 3 + SOURCE_W + SINK_W + 1 + DATA_W + 1;

   tl_buffer_queued_fifo #(
      .W(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE)
   ) u_a_queue (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (auto_in.a_valid),
      .enq_ready (auto_in.a_ready),
      .enq_bits  (auto_in.a_bits),
      .deq_valid (auto_out.a_valid),
      .deq_ready (auto_out.a_ready),
      .deq_bits  (auto_out.a_bits)
   );

   tl_buffer_queued_fifo #(
      .W(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE)
   ) u_d_queue (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (auto_out.d_valid),
      .enq_ready (auto_out.d_ready),
      .enq_bits  (auto_out.d_bits),
      .deq_valid (auto_in.d_valid),
      .deq_ready (auto_in.d_ready),
      .deq_bits  (auto_in.d_bits)
   );
endmodule

// File: tb/tb_tl_buffer_queued.sv
// Bench for tl_buffer_queued: directed corner sequences, a passthrough vector
// table and randomized traffic checked against queue-based reference models.
module tb_tl_buffer_queued;
   localparam int ADDR_W   = 21;
   localparam int DATA_W   = 64;
   localparam int SOURCE_W = 5;
   localparam int SINK_W   = 1;
   localparam int AW       = 9 + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
   localparam int DW       = 8 + SOURCE_W + SINK_W + 1 + DATA_W + 1;
   localparam int SRC_LSB  = SINK_W + 1 + DATA_W + 1;
   localparam int NV       = 6;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [AW-1:0] qa[$];
   logic [DW-1:0] qd[$];

   tl_buffer_queued_if #(.AW(AW), .DW(DW)) in0 ();
   tl_buffer_queued_if #(.AW(AW), .DW(DW)) out0 ();
   tl_buffer_queued_if #(.AW(AW), .DW(DW)) in1 ();
   tl_buffer_queued_if #(.AW(AW), .DW(DW)) out1 ();
   tl_buffer_queued_if #(.AW(AW), .DW(DW)) in2 ();
   tl_buffer_queued_if #(.AW(AW), .DW(DW)) out2 ();

   tl_buffer_queued #(.A_DEPTH(2), .D_DEPTH(3)) u0 (
      .clock(clock), .reset(reset), .auto_in(in0.slave), .auto_out(out0.master));
   tl_buffer_queued #(.A_DEPTH(2), .D_DEPTH(0), .A_FLOW(1), .A_PIPE(1)) u1 (
      .clock(clock), .reset(reset), .auto_in(in1.slave), .auto_out(out1.master));
   tl_buffer_queued #(.A_DEPTH(0), .D_DEPTH(0)) u2 (
      .clock(clock), .reset(reset), .auto_in(in2.slave), .auto_out(out2.master));

   typedef struct {
      logic          av;
      logic [AW-1:0] ab;
      logic          ar;
      logic          dv;
      logic [DW-1:0] db;
      logic          dr;
      logic          e_av;
      logic [AW-1:0] e_ab;
      logic          e_ar;
      logic          e_dv;
      logic [DW-1:0] e_db;
      logic          e_dr;
   } vec_t;

   vec_t tv [NV];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] mk_a(input logic [20:0] addr, input logic [63:0] data,
                                          input logic [4:0] src, input logic corrupt);
      return {3'd4, 3'd0, 3'd3, src, addr, 8'hFF, data, corrupt};
   endfunction

   function automatic logic [DW-1:0] mk_d(input logic [4:0] src, input logic denied,
                                          input logic [63:0] data, input logic corrupt);
      return {3'd1, 2'd0, 3'd3, src, 1'b0, denied, data, corrupt};
   endfunction

   function automatic logic [AW-1:0] rnd_a();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[AW-1:0];
   endfunction

   function automatic logic [DW-1:0] rnd_d();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic idle();
      in0.a_valid  = 1'b0; in0.a_bits  = '0; in0.d_ready  = 1'b0;
      out0.a_ready = 1'b0; out0.d_valid = 1'b0; out0.d_bits = '0;
      in1.a_valid  = 1'b0; in1.a_bits  = '0; in1.d_ready  = 1'b0;
      out1.a_ready = 1'b0; out1.d_valid = 1'b0; out1.d_bits = '0;
      in2.a_valid  = 1'b0; in2.a_bits  = '0; in2.d_ready  = 1'b0;
      out2.a_ready = 1'b0; out2.d_valid = 1'b0; out2.d_bits = '0;
   endtask

   // Random traffic on both channels of u0 against FIFO models (A depth 2, D depth 3).
   task automatic run_rand(input int n);
      logic a_enq, a_deq, d_enq, d_deq;
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         in0.a_valid  = 1'($urandom_range(0, 1));
         in0.a_bits   = rnd_a();
         out0.a_ready = 1'($urandom_range(0, 1));
         out0.d_valid = 1'($urandom_range(0, 1));
         out0.d_bits  = rnd_d();
         in0.d_ready  = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_a_valid", out0.a_valid, qa.size() > 0);
         chk("rnd_a_ready", in0.a_ready, qa.size() < 2);
         if (qa.size() > 0) chk("rnd_a_bits", out0.a_bits, qa[0]);
         chk("rnd_d_valid", in0.d_valid, qd.size() > 0);
         chk("rnd_d_ready", out0.d_ready, qd.size() < 3);
         if (qd.size() > 0) chk("rnd_d_bits", in0.d_bits, qd[0]);
         a_deq = (qa.size() > 0) && out0.a_ready;
         a_enq = in0.a_valid && (qa.size() < 2);
         d_deq = (qd.size() > 0) && in0.d_ready;
         d_enq = out0.d_valid && (qd.size() < 3);
         if (a_deq) void'(qa.pop_front());
         if (a_enq) qa.push_back(in0.a_bits);
         if (d_deq) void'(qd.pop_front());
         if (d_enq) qd.push_back(out0.d_bits);
      end
   endtask

   initial begin
      logic [AW-1:0] b;
      logic [AW-1:0] fb [3];
      logic [AW-1:0] pb [3];
      logic [DW-1:0] cur_d;
      int idx, got, sent, rcv;
      logic d_enq, d_deq;

      reset = 1'b1;
      idle();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_out_a_valid", out0.a_valid, 1'b0);
      chk("rst_in_a_ready", in0.a_ready, 1'b1);
      chk("rst_in_d_valid", in0.d_valid, 1'b0);
      chk("rst_out_d_ready", out0.d_ready, 1'b1);
      chk("rst_u1_in_a_ready", in1.a_ready, 1'b1);

      // Single beat: one cycle of latency, then held until taken.
      b = mk_a(21'h1000, 64'hDEADBEEF, 5'd1, 1'b0);
      @(negedge clock);
      in0.a_valid = 1'b1; in0.a_bits = b; out0.a_ready = 1'b0;
      #1;
      chk("single_lat", out0.a_valid, 1'b0);
      chk("single_acc", in0.a_ready, 1'b1);
      @(negedge clock);
      in0.a_valid = 1'b0;
      #1;
      chk("single_valid", out0.a_valid, 1'b1);
      chk("single_bits", out0.a_bits, b);
      @(negedge clock);
      #1;
      chk("single_hold_valid", out0.a_valid, 1'b1);
      chk("single_hold_bits", out0.a_bits, b);
      out0.a_ready = 1'b1;
      @(negedge clock);
      out0.a_ready = 1'b0;
      #1;
      chk("single_drained", out0.a_valid, 1'b0);

      // Fill depth 2 with three beats, then release and check order.
      for (int k = 0; k < 3; k++) fb[k] = mk_a(21'(32'h2000 + k), {$urandom(), $urandom()}, 5'(k), 1'b0);
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         in0.a_valid = 1'b1; in0.a_bits = fb[idx];
         #1;
         chk("fill_ready", in0.a_ready, k < 2);
         if (in0.a_ready) idx++;
      end
      chk("fill_accepted", idx, 2);
      got = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clock);
         out0.a_ready = 1'b1;
         in0.a_valid  = (idx < 3);
         in0.a_bits   = fb[(idx < 3) ? idx : 0];
         #1;
         if (out0.a_valid) begin
            chk("fill_order", out0.a_bits, fb[got]);
            got++;
         end
         if (in0.a_valid && in0.a_ready) idx++;
      end
      chk("fill_count", got, 3);
      in0.a_valid = 1'b0; out0.a_ready = 1'b0;

      // D channel depth 3: ten back-to-back beats, random consumer.
      qd.delete();
      sent = 0; rcv = 0;
      cur_d = mk_d(5'd0, 1'b0, {$urandom(), $urandom()}, 1'b0);
      for (int c = 0; c < 200 && rcv < 10; c++) begin
         @(negedge clock);
         out0.d_valid = (sent < 10);
         out0.d_bits  = cur_d;
         in0.d_ready  = 1'($urandom_range(0, 1));
         #1;
         chk("wrap_ready", out0.d_ready, qd.size() < 3);
         chk("wrap_valid", in0.d_valid, qd.size() > 0);
         d_deq = (qd.size() > 0) && in0.d_ready;
         d_enq = out0.d_valid && (qd.size() < 3);
         if (qd.size() > 0) begin
            chk("wrap_bits", in0.d_bits, qd[0]);
            chk("wrap_src", in0.d_bits[SRC_LSB +: SOURCE_W], 5'(rcv));
         end
         if (d_deq) begin
            void'(qd.pop_front());
            rcv++;
         end
         if (d_enq) begin
            qd.push_back(cur_d);
            sent++;
            cur_d = mk_d(5'(sent), 1'b0, {$urandom(), $urandom()}, 1'b0);
         end
      end
      chk("wrap_done", rcv, 10);
      out0.d_valid = 1'b0; in0.d_ready = 1'b0;

      // Reset with beats queued: old beats vanish, new beat comes out first.
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         in0.a_valid  = 1'b1; in0.a_bits  = mk_a(21'(32'h4000 + k), 64'h0BAD, 5'(k), 1'b0);
         out0.d_valid = 1'b1; out0.d_bits = mk_d(5'(k), 1'b0, 64'h0BAD, 1'b0);
      end
      @(negedge clock);
      idle();
      #1;
      chk("prerst_a_valid", out0.a_valid, 1'b1);
      chk("prerst_a_full", in0.a_ready, 1'b0);
      chk("prerst_d_valid", in0.d_valid, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midrst_a_valid", out0.a_valid, 1'b0);
      chk("midrst_a_ready", in0.a_ready, 1'b1);
      chk("midrst_d_valid", in0.d_valid, 1'b0);
      chk("midrst_d_ready", out0.d_ready, 1'b1);
      b = mk_a(21'h5000, 64'h600D, 5'd7, 1'b0);
      in0.a_valid = 1'b1; in0.a_bits = b;
      @(negedge clock);
      in0.a_valid = 1'b0; out0.a_ready = 1'b1;
      #1;
      chk("postrst_valid", out0.a_valid, 1'b1);
      chk("postrst_bits", out0.a_bits, b);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         #1;
         chk("postrst_no_old", out0.a_valid, 1'b0);
      end
      out0.a_ready = 1'b0;

      qa.delete();
      qd.delete();
      run_rand(300);
      idle();

      // Flow: empty queue with ready consumer passes the beat in the same cycle.
      b = mk_a(21'h3000, 64'h5555, 5'd5, 1'b0);
      for (int k = 0; k < 3; k++) pb[k] = mk_a(21'(32'h3100 + k), {$urandom(), $urandom()}, 5'(k + 8), 1'b0);
      // Drain anything the random phase left, then start clean.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      in1.a_valid = 1'b1; in1.a_bits = b; out1.a_ready = 1'b1;
      #1;
      chk("flow_valid", out1.a_valid, 1'b1);
      chk("flow_bits", out1.a_bits, b);
      chk("flow_ready", in1.a_ready, 1'b1);
      @(negedge clock);
      in1.a_valid = 1'b0;
      #1;
      chk("flow_not_stored", out1.a_valid, 1'b0);
      @(negedge clock);
      out1.a_ready = 1'b0; in1.a_valid = 1'b1; in1.a_bits = pb[0];
      #1;
      chk("flow_stall_valid", out1.a_valid, 1'b1);
      chk("flow_stall_bits", out1.a_bits, pb[0]);
      @(negedge clock);
      in1.a_bits = pb[1];
      #1;
      chk("pipe_fill_ready", in1.a_ready, 1'b1);
      chk("pipe_head", out1.a_bits, pb[0]);
      @(negedge clock);
      in1.a_bits = pb[2];
      #1;
      chk("pipe_full_stall", in1.a_ready, 1'b0);
      out1.a_ready = 1'b1;
      #1;
      chk("pipe_ready", in1.a_ready, 1'b1);
      chk("pipe_head2", out1.a_bits, pb[0]);
      @(negedge clock);
      in1.a_valid = 1'b0; out1.a_ready = 1'b0;
      #1;
      chk("pipe_still_full", in1.a_ready, 1'b0);
      chk("pipe_next_valid", out1.a_valid, 1'b1);
      chk("pipe_next", out1.a_bits, pb[1]);
      out1.a_ready = 1'b1;
      @(negedge clock);
      #1;
      chk("pipe_last", out1.a_bits, pb[2]);
      @(negedge clock);
      out1.a_ready = 1'b0;
      #1;
      chk("pipe_empty", out1.a_valid, 1'b0);

      // Zero-depth passthrough vectors (u2 both channels, u1 D channel).
      tv[0].av = 1'b1; tv[0].ab = mk_a(21'h1FFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1);
      tv[0].ar = 1'b0; tv[0].dv = 1'b1; tv[0].db = mk_d(5'd3, 1'b1, 64'h1234, 1'b1); tv[0].dr = 1'b1;
      tv[1].av = 1'b0; tv[1].ab = mk_a(21'h0, 64'h0, 5'd0, 1'b0);
      tv[1].ar = 1'b1; tv[1].dv = 1'b0; tv[1].db = mk_d(5'd0, 1'b0, 64'h0, 1'b0); tv[1].dr = 1'b0;
      tv[2].av = 1'b1; tv[2].ab = mk_a(21'h0ABCD, 64'hCAFE_F00D_0000_0001, 5'd9, 1'b0);
      tv[2].ar = 1'b1; tv[2].dv = 1'b1; tv[2].db = mk_d(5'd9, 1'b1, 64'h8000_0000_0000_0000, 1'b0); tv[2].dr = 1'b0;
      for (int i = 3; i < NV; i++) begin
         tv[i].av = 1'($urandom_range(0, 1)); tv[i].ab = rnd_a(); tv[i].ar = 1'($urandom_range(0, 1));
         tv[i].dv = 1'($urandom_range(0, 1)); tv[i].db = rnd_d(); tv[i].dr = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NV; i++) begin
         tv[i].e_av = tv[i].av; tv[i].e_ab = tv[i].ab; tv[i].e_ar = tv[i].ar;
         tv[i].e_dv = tv[i].dv; tv[i].e_db = tv[i].db; tv[i].e_dr = tv[i].dr;
      end
      for (int i = 0; i < NV; i++) begin
         @(negedge clock);
         in2.a_valid  = tv[i].av; in2.a_bits  = tv[i].ab; out2.a_ready = tv[i].ar;
         out2.d_valid = tv[i].dv; out2.d_bits = tv[i].db; in2.d_ready  = tv[i].dr;
         out1.d_valid = tv[i].dv; out1.d_bits = tv[i].db; in1.d_ready  = tv[i].dr;
         #1;
         chk("pt_a_valid", out2.a_valid, tv[i].e_av);
         chk("pt_a_bits", out2.a_bits, tv[i].e_ab);
         chk("pt_a_ready", in2.a_ready, tv[i].e_ar);
         chk("pt_d_valid", in2.d_valid, tv[i].e_dv);
         chk("pt_d_bits", in2.d_bits, tv[i].e_db);
         chk("pt_d_ready", out2.d_ready, tv[i].e_dr);
         chk("pt_u1_d_valid", in1.d_valid, tv[i].e_dv);
         chk("pt_u1_d_bits", in1.d_bits, tv[i].e_db);
         chk("pt_u1_d_ready", out1.d_ready, tv[i].e_dr);
      end

      idle();
      @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tl_buffer_queued.md
Name: tl_buffer_queued

Overview:
Parametrised TileLink-UL buffer between an inner (auto_in) and outer (auto_out) port. Inserts an independent FIFO on the A channel (in→out) and on the D channel (out→in), each with configurable depth and optional flow/pipe modes. Depth 0 on a channel degenerates to a wire (zero-latency passthrough). Used to cut timing paths on periphery crossbar links.

Parameters:
ADDR_W, 21, A address width
DATA_W, 64, data width (multiple of 8); mask width is DATA_W/8
SOURCE_W, 5, source id width
SINK_W, 1, sink id width
A_DEPTH, 2, A-channel entries (0 = passthrough)
D_DEPTH, 2, D-channel entries (0 = passthrough)
A_FLOW, 0, 1 = empty A queue forwards input in same cycle
A_PIPE, 0, 1 = full A queue accepts input when output fires
D_FLOW, 0, same as A_FLOW for D
D_PIPE, 0, same as A_PIPE for D

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
auto_in_a_valid  in  1  inner A valid
auto_in_a_ready  out  1  inner A ready
auto_in_a_bits  in  AW  packed A: {opcode[3],param[3],size[3],source[SOURCE_W],address[ADDR_W],mask[DATA_W/8],data[DATA_W],corrupt[1]}, MSB first; AW = sum
auto_out_a_valid  out  1  outer A valid
auto_out_a_ready  in  1  outer A ready
auto_out_a_bits  out  AW  packed A, same layout
auto_out_d_valid  in  1  outer D valid
auto_out_d_ready  out  1  outer D ready
auto_out_d_bits  in  DW  packed D: {opcode[3],param[2],size[3],source[SOURCE_W],sink[SINK_W],denied[1],data[DATA_W],corrupt[1]}; DW = sum
auto_in_d_valid  out  1  inner D valid
auto_in_d_ready  in  1  inner D ready
auto_in_d_bits  out  DW  packed D, same layout

Behaviour:
- One clock; reset synchronous, active-high. Reset clears count, enq/deq pointers, full flag of both queues. After reset: auto_out_a_valid=0, auto_in_d_valid=0, auto_in_a_ready=1, auto_out_d_ready=1 (depth>0). Storage RAM not reset.
- Each channel queue identical, parametrised by DEPTH/FLOW/PIPE; enq side = producer, deq side = consumer.
- Enq fire = enq_valid & enq_ready; deq fire = deq_valid & deq_ready. Data stored on enq fire at enq_ptr; deq_bits = ram[deq_ptr]. Pointers wrap DEPTH-1→0 (non-power-of-2 depths legal). Count width clog2(DEPTH+1).
- Normal mode: enq_ready = !full; deq_valid = !empty; latency enq→deq = 1 cycle minimum. Simultaneous enq+deq fire: count unchanged, both pointers advance.
- FLOW=1: when empty, deq_valid = enq_valid and deq_bits = enq bits combinationally; if deq_ready in same cycle, entry is not written and count stays 0 (latency 0).
- PIPE=1: when full, enq_ready = deq_ready; simultaneous fire keeps count = DEPTH.
- DEPTH=0: all signals wired straight through (ready/valid/bits), FLOW/PIPE ignored, no state.
- Valid deq output held stable with bits until fired (TileLink irrevocability); queue never drops or reorders beats.
- Full: enq_ready=0 (unless PIPE and deq_ready); input beats stalled, no overwrite. Empty: deq_valid=0 (unless FLOW).
- A and D queues fully independent; no ordering coupling between channels.
- Reset mid-transfer: all buffered beats discarded, valids drop next cycle; upstream must also reset.
- No X propagation on output valids; bits may be X only when valid=0.

Test Plan:
- Reset, A_DEPTH=2: after reset auto_out_a_valid=0, auto_in_a_ready=1; enq one beat (address=0x1000, data=0xDEADBEEF) → appears on auto_out_a one cycle later, held until auto_out_a_ready=1.
- Fill: auto_out_a_ready=0, push 3 beats into depth 2 → ready drops after 2 accepts, 3rd beat stalled; release ready → beats 1,2,3 emerge in order, no loss.
- Wrap/streaming: D_DEPTH=3, 10 back-to-back beats with random auto_in_d_ready → sources 0..9 in order, count never exceeds 3, pointers wrap cleanly.
- FLOW=1 empty queue, out ready=1: beat with source=5 appears on output same cycle, count stays 0; PIPE=1 full queue with out ready=1: in ready=1, count stays at DEPTH.
- DEPTH=0 both channels: every port equals its counterpart combinationally, including denied=1 and corrupt=1 passthrough.
- Reset asserted with 2 beats queued → next cycle valids=0, in ready=1; post-reset beat emitted first, old beats never appear.
